// File: rtl/gpio_pkg.sv
// Shared constants for the iomem GPIO peripheral: register byte offsets and width limit.
package gpio_pkg;

  localparam int GPIO_MAX_WIDTH = 32;

  localparam logic [7:0] GPIO_OFF_OUT  = 8'h00;
  localparam logic [7:0] GPIO_OFF_IN   = 8'h04;
  localparam logic [7:0] GPIO_OFF_DIR  = 8'h08;
  localparam logic [7:0] GPIO_OFF_SET  = 8'h0C;
  localparam logic [7:0] GPIO_OFF_CLR  = 8'h10;
  localparam logic [7:0] GPIO_OFF_TGL  = 8'h14;
  localparam logic [7:0] GPIO_OFF_IE   = 8'h18;
  localparam logic [7:0] GPIO_OFF_IPOL = 8'h1C;
  localparam logic [7:0] GPIO_OFF_IS   = 8'h20;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage input synchronizer plus a history flop that yields per-pin rise/fall strobes.
module gpio_sync_edge #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk_bufg,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/iomem_gpio.sv
// PicoSoC iomem GPIO: per-pin direction, atomic set/clear/toggle, and edge interrupts.
module iomem_gpio
  import gpio_pkg::*;
#(
  parameter int         NUM_GPIO    = 8,
  parameter logic [7:0] BASE_HI     = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                clk_bufg,
  input  logic                resetn,
  input  logic                iomem_valid,
  output logic                iomem_ready,
  input  logic [3:0]          iomem_wstrb,
  input  logic [31:0]         iomem_addr,
  input  logic [31:0]         iomem_wdata,
  output logic [31:0]         iomem_rdata,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oe,
  output logic                irq
);

  if (NUM_GPIO < 1 || NUM_GPIO > GPIO_MAX_WIDTH) begin : g_bad_width
    $error("iomem_gpio: NUM_GPIO out of range");
  end
  if (SYNC_STAGES < 2) begin : g_bad_stages
    $error("iomem_gpio: SYNC_STAGES must be at least 2");
  end

  logic                sel;
  logic                wr;
  logic [7:0]          off;
  logic [31:0]         bmask;
  logic [NUM_GPIO-1:0] wm;
  logic [NUM_GPIO-1:0] wd;
  logic [NUM_GPIO-1:0] out_r, dir_r, ie_r, ipol_r, is_r;
  logic [NUM_GPIO-1:0] in_s, rise, fall, edge_det, is_clr;
  logic [31:0]         rd_val;
  logic                unused;

  assign sel   = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_HI);
  assign wr    = sel && (iomem_wstrb != 4'b0000);
  assign off   = {iomem_addr[7:2], 2'b00};
  assign bmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                  {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wm    = bmask[NUM_GPIO-1:0];
  assign wd    = iomem_wdata[NUM_GPIO-1:0] & wm;

  assign unused = ^{iomem_addr[23:8], iomem_addr[1:0], iomem_wdata, bmask};

  gpio_sync_edge #(
    .WIDTH (NUM_GPIO),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_bufg(clk_bufg),
    .resetn  (resetn),
    .din     (gpio_in),
    .sync    (in_s),
    .rise    (rise),
    .fall    (fall)
  );

  assign edge_det = (ipol_r & rise) | (~ipol_r & fall);
  assign is_clr   = (wr && off == GPIO_OFF_IS) ? wd : '0;

  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      out_r  <= '0;
      dir_r  <= '0;
      ie_r   <= '0;
      ipol_r <= '0;
    end else if (wr) begin
      case (off)
        GPIO_OFF_OUT:  out_r  <= (out_r & ~wm) | wd;
        GPIO_OFF_SET:  out_r  <= out_r | wd;
        GPIO_OFF_CLR:  out_r  <= out_r & ~wd;
        GPIO_OFF_TGL:  out_r  <= out_r ^ wd;
        GPIO_OFF_DIR:  dir_r  <= (dir_r & ~wm) | wd;
        GPIO_OFF_IE:   ie_r   <= (ie_r & ~wm) | wd;
        GPIO_OFF_IPOL: ipol_r <= (ipol_r & ~wm) | wd;
        default: ;
      endcase
    end
  end

  // A fresh edge is OR-ed in after the W1C so a coincident set always survives.
  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      is_r <= '0;
      irq  <= 1'b0;
    end else begin
      is_r <= (is_r & ~is_clr) | (edge_det & ie_r);
      irq  <= |(is_r & ie_r);
    end
  end

  always_comb begin
    rd_val = '0;
    case (off)
      GPIO_OFF_OUT:  rd_val[NUM_GPIO-1:0] = out_r;
      GPIO_OFF_IN:   rd_val[NUM_GPIO-1:0] = in_s;
      GPIO_OFF_DIR:  rd_val[NUM_GPIO-1:0] = dir_r;
      GPIO_OFF_IE:   rd_val[NUM_GPIO-1:0] = ie_r;
      GPIO_OFF_IPOL: rd_val[NUM_GPIO-1:0] = ipol_r;
      GPIO_OFF_IS:   rd_val[NUM_GPIO-1:0] = is_r;
      default:       rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= sel;
      if (sel) iomem_rdata <= rd_val;
    end
  end

  assign gpio_out = out_r;
  assign gpio_oe  = dir_r;

endmodule

// File: tb/tb_iomem_gpio.sv
// Randomized self-checking bench for iomem_gpio with a register-level reference model.
module tb_iomem_gpio;
  import gpio_pkg::*;

  localparam int SS = 2;
  localparam logic [31:0] WM8 = 32'h0000_00FF;

  logic        clk_bufg = 1'b0;
  logic        resetn = 1'b0;
  logic        valid8 = 1'b0, valid4 = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready8, ready4, irq8, irq4;
  logic [31:0] rdata8, rdata4;
  logic [7:0]  gin8 = '0, gout8, goe8;
  logic [3:0]  gin4 = '0, gout4, goe4;

  int passes = 0;
  int checks = 0;

  logic [31:0] m_out, m_in, m_dir, m_ie, m_ipol, m_is;

  always #5 clk_bufg = ~clk_bufg;

  iomem_gpio #(.NUM_GPIO(8), .BASE_HI(8'h03), .SYNC_STAGES(SS)) dut8 (
    .clk_bufg(clk_bufg), .resetn(resetn), .iomem_valid(valid8), .iomem_ready(ready8),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata8),
    .gpio_in(gin8), .gpio_out(gout8), .gpio_oe(goe8), .irq(irq8));

  iomem_gpio #(.NUM_GPIO(4), .BASE_HI(8'h03), .SYNC_STAGES(SS)) dut4 (
    .clk_bufg(clk_bufg), .resetn(resetn), .iomem_valid(valid4), .iomem_ready(ready4),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata4),
    .gpio_in(gin4), .gpio_out(gout4), .gpio_oe(goe4), .irq(irq4));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] byteMask(input logic [3:0] ws);
    return {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
  endfunction

  function automatic logic [31:0] addrFor(input logic [7:0] off);
    logic [15:0] junk;
    junk = 16'($urandom);
    return {8'h03, junk, off[7:2], 2'b00};
  endfunction

  function automatic void modelReset();
    m_out = '0; m_dir = '0; m_ie = '0; m_ipol = '0; m_is = '0;
  endfunction

  function automatic void modelWrite(input logic [7:0] off, input logic [3:0] ws, input logic [31:0] d);
    logic [31:0] bm, dm;
    bm = byteMask(ws) & WM8;
    dm = d & bm;
    case (off)
      GPIO_OFF_OUT:  m_out  = (m_out & ~bm) | dm;
      GPIO_OFF_DIR:  m_dir  = (m_dir & ~bm) | dm;
      GPIO_OFF_SET:  m_out  = m_out | dm;
      GPIO_OFF_CLR:  m_out  = m_out & ~dm;
      GPIO_OFF_TGL:  m_out  = m_out ^ dm;
      GPIO_OFF_IE:   m_ie   = (m_ie & ~bm) | dm;
      GPIO_OFF_IPOL: m_ipol = (m_ipol & ~bm) | dm;
      GPIO_OFF_IS:   m_is   = m_is & ~dm;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] modelRead(input logic [7:0] off);
    case (off)
      GPIO_OFF_OUT:  return m_out;
      GPIO_OFF_IN:   return m_in;
      GPIO_OFF_DIR:  return m_dir;
      GPIO_OFF_IE:   return m_ie;
      GPIO_OFF_IPOL: return m_ipol;
      GPIO_OFF_IS:   return m_is;
      default:       return 32'h0;
    endcase
  endfunction

  // Whole-word view of a pin change: each toggled bit is an edge of known direction.
  function automatic void modelPins(input logic [31:0] n);
    logic [31:0] ev;
    ev = ((n & ~m_in & m_ipol) | (m_in & ~n & ~m_ipol)) & WM8;
    m_is = m_is | (ev & m_ie);
    m_in = n & WM8;
  endfunction

  task automatic busAccess(input int which, input logic [31:0] a, input logic [3:0] ws,
                           input logic [31:0] wd, input bit expectResp, output logic [31:0] rd);
    int cyc;
    bit got;
    @(negedge clk_bufg);
    addr = a; wstrb = ws; wdata = wd;
    if (which == 4) valid4 = 1'b1; else valid8 = 1'b1;
    cyc = 0; got = 0; rd = '0;
    while (!got && cyc < 10) begin
      @(posedge clk_bufg); #1;
      cyc++;
      if ((which == 4) ? ready4 : ready8) begin
        got = 1;
        rd = (which == 4) ? rdata4 : rdata8;
      end
    end
    valid8 = 1'b0; valid4 = 1'b0; wstrb = 4'h0;
    if (expectResp) begin
      checkOutput("ready_latency", cyc, 1);
      @(posedge clk_bufg); #1;
      checkOutput("ready_pulse_end", {31'b0, (which == 4) ? ready4 : ready8}, 0);
    end else begin
      checkOutput("unselected_ready", {31'b0, got}, 0);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] off, input logic [3:0] ws, input logic [31:0] d);
    logic [31:0] rd;
    busAccess(8, addrFor(off), ws, d, 1'b1, rd);
    modelWrite(off, ws, d);
  endtask

  task automatic readCheck(input string tag, input logic [7:0] off);
    logic [31:0] rd;
    busAccess(8, addrFor(off), 4'h0, $urandom, 1'b1, rd);
    checkOutput(tag, rd, modelRead(off));
  endtask

  task automatic setPins(input logic [7:0] n);
    @(negedge clk_bufg);
    gin8 = n;
    modelPins({24'h0, n});
    repeat (SS + 3) @(posedge clk_bufg);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation timed out");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  off;
    bit          anyReady;
    int          op;

    modelReset();
    m_in = '0;
    repeat (3) @(posedge clk_bufg);
    #1;
    checkOutput("reset_ready", {31'b0, ready8}, 0);
    checkOutput("reset_irq", {31'b0, irq8}, 0);
    @(negedge clk_bufg) resetn = 1'b1;

    for (int i = 0; i <= 8; i++) readCheck("reset_read", 8'(i * 4));

    applyStimulus(GPIO_OFF_OUT, 4'b0001, 32'h0000_00A5);
    checkOutput("out_a5", {24'h0, gout8}, 32'hA5);
    readCheck("out_rb", GPIO_OFF_OUT);
    applyStimulus(GPIO_OFF_SET, 4'hF, 32'h0A);
    checkOutput("out_set", {24'h0, gout8}, 32'hAF);
    readCheck("out_rb", GPIO_OFF_OUT);
    applyStimulus(GPIO_OFF_CLR, 4'hF, 32'h81);
    checkOutput("out_clr", {24'h0, gout8}, 32'h2E);
    readCheck("out_rb", GPIO_OFF_OUT);
    applyStimulus(GPIO_OFF_TGL, 4'hF, 32'hFF);
    checkOutput("out_tgl", {24'h0, gout8}, 32'hD1);
    readCheck("out_rb", GPIO_OFF_OUT);
    readCheck("set_reads_zero", GPIO_OFF_SET);

    busAccess(4, {8'h03, 16'h0, GPIO_OFF_DIR}, 4'hF, 32'hFFFF_FFFF, 1'b1, rd);
    busAccess(4, {8'h03, 16'h0, GPIO_OFF_OUT}, 4'hF, 32'hFFFF_FFFF, 1'b1, rd);
    busAccess(4, {8'h03, 16'h0, GPIO_OFF_DIR}, 4'h0, 32'h0, 1'b1, rd);
    checkOutput("w4_dir_rb", rd, 32'h0000_000F);
    busAccess(4, {8'h03, 16'h0, GPIO_OFF_OUT}, 4'h0, 32'h0, 1'b1, rd);
    checkOutput("w4_out_rb", rd, 32'h0000_000F);
    checkOutput("w4_oe", {28'h0, goe4}, 32'hF);
    busAccess(4, {8'h02, 16'h0, GPIO_OFF_OUT}, 4'h0, 32'h0, 1'b0, rd);
    busAccess(8, {8'h02, 16'h0, GPIO_OFF_OUT}, 4'hF, 32'h0, 1'b0, rd);
    checkOutput("unselected_no_write", {24'h0, gout8}, m_out);

    applyStimulus(GPIO_OFF_IE, 4'hF, 32'h01);
    applyStimulus(GPIO_OFF_IPOL, 4'hF, 32'h01);
    @(negedge clk_bufg);
    gin8[0] = 1'b1;
    modelPins({24'h0, gin8});
    repeat (SS + 1) @(posedge clk_bufg);
    #1;
    checkOutput("irq_before", {31'b0, irq8}, 0);
    @(posedge clk_bufg); #1;
    checkOutput("irq_rise", {31'b0, irq8}, 1);
    readCheck("is_rise", GPIO_OFF_IS);
    applyStimulus(GPIO_OFF_IS, 4'hF, 32'h01);
    checkOutput("irq_w1c", {31'b0, irq8}, 0);
    readCheck("is_w1c", GPIO_OFF_IS);

    applyStimulus(GPIO_OFF_IPOL, 4'hF, 32'h00);
    applyStimulus(GPIO_OFF_IE, 4'hF, 32'h02);
    setPins(gin8 | 8'h02);
    readCheck("is_no_rise", GPIO_OFF_IS);
    @(negedge clk_bufg);
    gin8[1] = 1'b0;
    repeat (SS) @(posedge clk_bufg);
    applyStimulus(GPIO_OFF_IS, 4'hF, 32'h02);
    modelPins({24'h0, gin8});
    readCheck("is_set_wins", GPIO_OFF_IS);
    checkOutput("is_set_wins_const", m_is, 32'h02);
    checkOutput("irq_fall", {31'b0, irq8}, 1);

    for (int i = 0; i < 4; i++) setPins(gin8 ^ 8'h04);
    readCheck("is_masked", GPIO_OFF_IS);
    applyStimulus(GPIO_OFF_IE, 4'hF, 32'h00);
    checkOutput("irq_ie_off", {31'b0, irq8}, 0);
    readCheck("is_kept", GPIO_OFF_IS);

    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 2);
      off = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(9, 63) * 4) : 8'($urandom_range(0, 8) * 4);
      case (op)
        0: applyStimulus(off, 4'($urandom_range(1, 15)), $urandom);
        1: readCheck("rand_read", off);
        default: setPins(8'($urandom));
      endcase
      checkOutput("rand_out", {24'h0, gout8}, m_out);
      checkOutput("rand_oe", {24'h0, goe8}, m_dir);
      checkOutput("rand_irq", {31'b0, irq8}, {31'b0, |(m_is & m_ie)});
    end
    readCheck("rand_in", GPIO_OFF_IN);

    applyStimulus(GPIO_OFF_OUT, 4'hF, 32'h5A);
    applyStimulus(GPIO_OFF_DIR, 4'hF, 32'hC3);
    setPins(8'h00);
    @(negedge clk_bufg);
    valid8 = 1'b1; addr = {8'h03, 16'h0, GPIO_OFF_OUT}; wstrb = 4'h0; resetn = 1'b0;
    anyReady = 0;
    repeat (3) begin
      @(posedge clk_bufg); #1;
      if (ready8) anyReady = 1;
    end
    checkOutput("reset_abort_ready", {31'b0, anyReady}, 0);
    valid8 = 1'b0;
    @(negedge clk_bufg) resetn = 1'b1;
    modelReset();
    checkOutput("post_reset_out", {24'h0, gout8}, 0);
    checkOutput("post_reset_oe", {24'h0, goe8}, 0);
    checkOutput("post_reset_irq", {31'b0, irq8}, 0);
    for (int i = 0; i <= 8; i++) readCheck("post_reset_read", 8'(i * 4));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
